// File: rtl/downcounter_4d.sv
// downcounter_4d: loadable mm:ss BCD countdown timer.
// A value is loaded (clamped per digit), then counted down once per tick
// while running, stopping at 00:00 with a done level and a one-cycle
// expired pulse. The FSM state is held in `state` for hierarchical probing.
module downcounter_4d #(
  parameter int BCD_BIT_WIDTH = 4,
  parameter int SEC_TENS_MAX  = 5,
  parameter int MIN_TENS_MAX  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     load,
  input  logic                     start_stop,
  input  logic [BCD_BIT_WIDTH-1:0] set_digit0,
  input  logic [BCD_BIT_WIDTH-1:0] set_digit1,
  input  logic [BCD_BIT_WIDTH-1:0] set_digit2,
  input  logic [BCD_BIT_WIDTH-1:0] set_digit3,
  output logic [BCD_BIT_WIDTH-1:0] digit0,
  output logic [BCD_BIT_WIDTH-1:0] digit1,
  output logic [BCD_BIT_WIDTH-1:0] digit2,
  output logic [BCD_BIT_WIDTH-1:0] digit3,
  output logic                     running,
  output logic                     done,
  output logic                     expired
);

  localparam int W = BCD_BIT_WIDTH;
  localparam logic [W-1:0] ZERO     = '0;
  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] NINE     = W'(9);
  localparam logic [W-1:0] SEC_TMAX = W'(SEC_TENS_MAX);
  localparam logic [W-1:0] MIN_TMAX = W'(MIN_TENS_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [W-1:0] d0_next, d1_next, d2_next, d3_next;
  logic [W-1:0] dec0, dec1, dec2, dec3;
  logic [W-1:0] ld0, ld1, ld2, ld3;
  logic         borrow1, borrow2, borrow3;
  logic         value_nonzero, dec_zero;
  logic         expired_next;

  // Out-of-range set values load as the digit's limit, so digits stay legal.
  function automatic logic [W-1:0] clamp(input logic [W-1:0] v,
                                         input logic [W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Load values after per-digit saturation.
  always_comb begin
    ld0 = clamp(set_digit0, NINE);
    ld1 = clamp(set_digit1, SEC_TMAX);
    ld2 = clamp(set_digit2, NINE);
    ld3 = clamp(set_digit3, MIN_TMAX);
  end

  // One-step decrement with a borrow rippling from seconds units upward.
  // digit3 never wraps: 00:00 is caught as terminal before it could.
  always_comb begin
    borrow1 = (digit0 == ZERO);
    dec0    = borrow1 ? NINE : (digit0 - ONE);
    borrow2 = borrow1 && (digit1 == ZERO);
    dec1    = borrow1 ? ((digit1 == ZERO) ? SEC_TMAX : (digit1 - ONE)) : digit1;
    borrow3 = borrow2 && (digit2 == ZERO);
    dec2    = borrow2 ? ((digit2 == ZERO) ? NINE : (digit2 - ONE)) : digit2;
    dec3    = borrow3 ? (digit3 - ONE) : digit3;
    value_nonzero = |{digit3, digit2, digit1, digit0};
    dec_zero      = ~|{dec3, dec2, dec1, dec0};
  end

  // Next-state and next-digit logic; load takes priority outside RUN, and
  // reaching 00:00 takes priority over a same-cycle pause request.
  always_comb begin
    state_next   = state;
    d0_next      = digit0;
    d1_next      = digit1;
    d2_next      = digit2;
    d3_next      = digit3;
    expired_next = 1'b0;
    unique case (state)
      IDLE, PAUSE, DONE: begin
        if (load) begin
          d0_next    = ld0;
          d1_next    = ld1;
          d2_next    = ld2;
          d3_next    = ld3;
          state_next = IDLE;
        end else if (start_stop) begin
          if (state == IDLE && value_nonzero) state_next = RUN;
          else if (state == PAUSE)            state_next = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          d0_next = dec0;
          d1_next = dec1;
          d2_next = dec2;
          d3_next = dec3;
          if (dec_zero) begin
            state_next   = DONE;
            expired_next = 1'b1;
          end else if (start_stop) begin
            state_next = PAUSE;
          end
        end else if (start_stop) begin
          state_next = PAUSE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, digit and status registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      digit0  <= '0;
      digit1  <= '0;
      digit2  <= '0;
      digit3  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      digit0  <= d0_next;
      digit1  <= d1_next;
      digit2  <= d2_next;
      digit3  <= d3_next;
      running <= (state_next == RUN);
      done    <= (state_next == DONE);
      expired <= expired_next;
    end
  end

endmodule

// File: tb/tb_downcounter_4d.sv
// tb_downcounter_4d: scoreboard bench for the mm:ss countdown timer.
// The reference model keeps the remaining time as a plain number of seconds
// and converts it to digits when an expectation is pushed.
module tb_downcounter_4d;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       tick, load, start_stop;
  logic [3:0] set_digit0, set_digit1, set_digit2, set_digit3;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, done, expired;

  always #5 clk = ~clk;

  downcounter_4d dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .start_stop (start_stop),
    .set_digit0 (set_digit0),
    .set_digit1 (set_digit1),
    .set_digit2 (set_digit2),
    .set_digit3 (set_digit3),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  // ---------------- scoreboard ----------------
  // Packed observation: {d3,d2,d1,d0,running,done,expired}
  localparam int OW = 19;
  logic [OW-1:0] exp_q[$];
  int checks_total  = 0;
  int checks_passed = 0;

  // Model: 0 idle, 1 run, 2 pause, 3 done; time in seconds.
  int m_state = 0;
  int m_secs  = 0;

  task automatic check(input string tag, input logic [OW-1:0] got,
                       input logic [OW-1:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h/%0h:%0h%0h r%0b d%0b e%0b, expected %0h%0h:%0h%0h r%0b d%0b e%0b",
                  tag, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                  exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
  endtask

  function automatic logic [OW-1:0] observe();
    return {digit3, digit2, digit1, digit0, running, done, expired};
  endfunction

  function automatic logic [OW-1:0] expect_vec(input int secs, input int st,
                                               input bit exp_pulse);
    int mm, ss;
    logic [3:0] e3, e2, e1, e0;
    mm = secs / 60;
    ss = secs % 60;
    e3 = 4'(mm / 10);
    e2 = 4'(mm % 10);
    e1 = 4'(ss / 10);
    e0 = 4'(ss % 10);
    return {e3, e2, e1, e0, (st == 1), (st == 3), exp_pulse};
  endfunction

  function automatic int sat(input logic [3:0] v, input int lim);
    return (int'(v) > lim) ? lim : int'(v);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    bit pulse;
    pulse = 1'b0;
    case (m_state)
      1: begin
        if (tick) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_state = 3; pulse = 1'b1; end
          else if (start_stop) m_state = 2;
        end else if (start_stop) m_state = 2;
      end
      default: begin
        if (load) begin
          m_secs = (sat(set_digit3, 5) * 10 + sat(set_digit2, 9)) * 60
                 + sat(set_digit1, 5) * 10 + sat(set_digit0, 9);
          m_state = 0;
        end else if (start_stop) begin
          if (m_state == 0 && m_secs != 0) m_state = 1;
          else if (m_state == 2)           m_state = 1;
        end
      end
    endcase
    exp_q.push_back(expect_vec(m_secs, m_state, pulse));
  endtask

  task automatic pop_check(input string tag);
    logic [OW-1:0] e;
    if (exp_q.size() == 0) begin
      checks_total++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, observe(), e);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive, predict, then compare at the
  // next falling edge once the DUT has registered the rising edge.
  task automatic step(input string tag, input logic t, input logic l,
                      input logic s, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    tick = t; load = l; start_stop = s;
    set_digit0 = a; set_digit1 = b; set_digit2 = c; set_digit3 = d;
    model_edge();
    @(negedge clk);
    pop_check(tag);
    tick = 1'b0; load = 1'b0; start_stop = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    step(tag, 1'b0, 1'b1, 1'b0, a, b, c, d);
  endtask

  task automatic do_ss(input string tag);
    step(tag, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic do_tick(input string tag);
    step(tag, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start_stop = 1'b0;
    set_digit0 = '0; set_digit1 = '0; set_digit2 = '0; set_digit3 = '0;
    #1;
    exp_q.push_back(expect_vec(0, 0, 1'b0));
    pop_check("reset_async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(expect_vec(0, 0, 1'b0));
    pop_check("reset_release");

    // start with 00:00 loaded is ignored
    do_ss("ss_empty_idle");
    do_tick("tick_idle");

    // 01:30 down through the minute borrow
    do_load("load_0130", 4'd0, 4'd3, 4'd1, 4'd0);
    do_ss("start_0130");
    for (int i = 0; i < 31; i++) do_tick("count_0130");

    // 00:02 to terminal count, then DONE holds
    do_load("load_0002", 4'd2, 4'd0, 4'd0, 4'd0);
    do_ss("start_0002");
    do_tick("tick_0001");
    do_tick("tick_done");
    do_tick("done_hold_tick");
    do_ss("done_hold_ss");
    do_load("load_after_done", 4'd5, 4'd0, 4'd0, 4'd0);

    // saturation on load
    do_load("load_clamp", 4'd12, 4'd7, 4'd15, 4'd9);

    // pause / resume at 10:00
    do_load("load_1000", 4'd0, 4'd0, 4'd0, 4'd1);
    do_ss("start_1000");
    do_ss("pause_1000");
    for (int i = 0; i < 5; i++) do_tick("paused_tick");
    do_ss("resume_1000");
    do_tick("tick_0959");
    step("load_tick_in_run", 1'b1, 1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 4'd3);
    step("load_ignored_run", 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 4'd3);
    do_ss("pause_for_load");
    step("load_ss_pause", 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0);

    // tick + start_stop at 00:01: DONE beats PAUSE
    do_ss("start_0001");
    step("tick_ss_done", 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    do_ss("done_after_race");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("random",
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
    end

    // asynchronous reset in the middle of a run
    do_load("load_0500", 4'd0, 4'd0, 4'd5, 4'd0);
    do_ss("start_0500");
    do_tick("tick_0459");
    do_tick("tick_0458");
    #2 rst = 1'b1;
    #1;
    m_state = 0; m_secs = 0;
    exp_q.push_back(expect_vec(0, 0, 1'b0));
    pop_check("rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    do_tick("tick_after_rst");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/downcounter_4d.md
Name: downcounter_4d

Overview:
- Countdown companion to the 4-digit mm:ss up-counter used in time-setting mode.
- Loads a BCD mm:ss value, then counts it down once per enable tick to 00:00 using a borrow chain across four BCD digits.
- Stops at 00:00 and flags completion. Feeds the 7-segment scan logic and the top-level mode FSM.

Parameters:
BCD_BIT_WIDTH, 4, width of each BCD digit
SEC_TENS_MAX, 5, maximum value of digit1 (tens of seconds)
MIN_TENS_MAX, 5, maximum value of digit3 (tens of minutes)

Ports:
clk  input  1  global clock
rst  input  1  asynchronous reset, active-high
tick  input  1  one-cycle count enable (1 Hz strobe from the frequency divider)
load  input  1  one-cycle strobe: copy set_digit0..3 into the counter
start_stop  input  1  one-cycle strobe (debounced, one-pulsed pushbutton): run/pause toggle
set_digit0  input  4  load value, seconds units
set_digit1  input  4  load value, seconds tens
set_digit2  input  4  load value, minutes units
set_digit3  input  4  load value, minutes tens
digit0  output  4  seconds units (rightmost)
digit1  output  4  seconds tens
digit2  output  4  minutes units
digit3  output  4  minutes tens
running  output  1  high while in RUN
done  output  1  high while in DONE
expired  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE, digits 0/0/0/0, and running, done and expired to 0.
- All outputs are registered. Digits update on the clk edge that samples the qualifying strobe.
- FSM states:
  - IDLE: value loaded, not counting.
  - RUN: counting down.
  - PAUSE: counting halted.
  - DONE: reached 00:00.
- Load saturation: each set digit is clamped on load. digit0 and digit2 clamp to 9; digit1 clamps to SEC_TENS_MAX; digit3 clamps to MIN_TENS_MAX. Values above the limit load as the limit.
- load:
  - Accepted in IDLE, PAUSE and DONE. Next state is IDLE, and done clears.
  - Ignored in RUN.
- start_stop:
  - IDLE, value nonzero -> RUN.
  - IDLE, value 00:00 -> ignored.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - DONE -> ignored.
- tick: acts only in RUN. It is ignored in IDLE, PAUSE and DONE.
- Decrement (RUN and tick):
  - digit0 decrements. If digit0 = 0, it wraps to 9 and borrows into digit1.
  - digit1 decrements on borrow. If digit1 = 0 at that point, it wraps to SEC_TENS_MAX and borrows into digit2.
  - digit2 decrements on borrow. If digit2 = 0 at that point, it wraps to 9 and borrows into digit3.
  - digit3 decrements on borrow. It never wraps, because 00:00 is caught first.
- Terminal count: if the decrement yields 00:00, the next state is DONE. done rises and expired pulses high for exactly one cycle, both on the same edge that writes 00:00.
- DONE holds 00:00. It is exited only by load or rst.
- Simultaneous events:
  - load + start_stop in IDLE/PAUSE/DONE: load wins, start_stop is dropped, state = IDLE.
  - tick + start_stop in RUN: the decrement is applied and the state goes to PAUSE. If that decrement reaches 00:00, DONE wins over PAUSE.
  - load + tick in RUN: load is ignored and the tick is applied.
- rst asserted mid-count clears immediately, without waiting for a clock edge.
- Digits never hold non-BCD values or exceed their per-digit limits.

Test Plan:
- Reset then release -> digits 0000, running/done/expired all 0. A start_stop pulse with no load leaves the state IDLE.
- Load 0,3,1,0 (01:30), pulse start_stop, apply 1 tick -> 01:29. After 30 more ticks (31 total from 01:30) -> 00:59, i.e. the minute borrows and digit1 wraps to 5.
- Load 00:02, start, apply 2 ticks -> 00:00. done=1 and expired is high for exactly one cycle on that edge. Further ticks and start_stop leave 00:00 and done=1. A subsequent load 5,0,0,0 -> 00:05 with done=0.
- Load set_digit0=12, set_digit1=7, set_digit2=15, set_digit3=9 -> digits read 59:59 (9,5,9,5).
- RUN at 10:00: start_stop -> PAUSE. Then 5 ticks -> value unchanged at 10:00. Then start_stop and 1 tick -> 09:59.
- Same-cycle tick + start_stop at 00:01 -> 00:00 and DONE, not PAUSE. Asserting rst asynchronously mid-run -> outputs clear before the next clk edge.
